// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding a single-cycle core.
// Issues one read per core PC over a valid/ready bus and holds the returned word
// until the core accepts it. Bus errors, misaligned PCs and response timeouts
// deliver NOP_INST together with a fault code. After a timeout the unit drains
// the late response before it issues another request.
module ifu_fetch #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [1:0]  fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned FAULT_W = 2;

  localparam logic [FAULT_W-1:0] F_NONE = 2'b00;
  localparam logic [FAULT_W-1:0] F_BUS  = 2'b01;
  localparam logic [FAULT_W-1:0] F_MIS  = 2'b10;
  localparam logic [FAULT_W-1:0] F_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t             state_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    inst_q;
  logic               inst_valid_q;
  logic [FAULT_W-1:0] fault_q;
  logic               mem_req_valid_q;
  logic               mem_resp_ready_q;
  logic [XLEN-1:0]    fetch_cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               drain_q;

  logic               drain_d;
  logic               resp_ready_d;
  logic               req_fire;
  logic               tmo_hit;

  // The latched PC doubles as the request address; it only changes in IDLE.
  assign mem_req_addr   = pc_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_resp_ready = mem_resp_ready_q;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign fault          = fault_q;
  assign fetch_cnt      = fetch_cnt_q;

  assign req_fire = mem_req_valid_q & mem_req_ready;
  // Expires on the WAIT cycle that would make the counter equal TIMEOUT.
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Drain flag and response-ready for the next cycle; a same-cycle response beats a timeout.
  always_comb begin
    drain_d      = drain_q;
    resp_ready_d = 1'b0;
    if (drain_q && mem_resp_valid) begin
      drain_d = 1'b0;
    end
    if ((state_q == S_WAIT) && !mem_resp_valid && tmo_hit) begin
      drain_d = 1'b1;
    end
    if ((state_q == S_REQ) && req_fire) begin
      resp_ready_d = 1'b1;
    end
    if ((state_q == S_WAIT) && !mem_resp_valid && !tmo_hit) begin
      resp_ready_d = 1'b1;
    end
    if (drain_d) begin
      resp_ready_d = 1'b1;
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      pc_q             <= '0;
      inst_q           <= '0;
      inst_valid_q     <= 1'b0;
      fault_q          <= F_NONE;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      fetch_cnt_q      <= '0;
      tmo_q            <= '0;
      drain_q          <= 1'b0;
    end else begin
      drain_q          <= drain_d;
      mem_resp_ready_q <= resp_ready_d;
      case (state_q)
        S_IDLE: begin
          pc_q <= pc_in;
          if (pc_in[1:0] != 2'b00) begin
            inst_q       <= NOP_INST;
            fault_q      <= F_MIS;
            inst_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end else begin
            mem_req_valid_q <= !drain_d;
            state_q         <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_fire) begin
            mem_req_valid_q <= 1'b0;
            tmo_q           <= '0;
            state_q         <= S_WAIT;
          end else begin
            mem_req_valid_q <= !drain_d;
          end
        end
        S_WAIT: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (mem_resp_valid) begin
            inst_q       <= mem_resp_err ? NOP_INST : mem_resp_data;
            fault_q      <= mem_resp_err ? F_BUS : F_NONE;
            inst_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end else if (tmo_hit) begin
            inst_q       <= NOP_INST;
            fault_q      <= F_TMO;
            inst_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= fetch_cnt_q + XLEN'(1);
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response is only legal while waiting for one or while draining a late one.
  stray_resp_a : assert property (@(posedge clk) disable iff (rst)
    !(mem_resp_valid && (state_q != S_WAIT) && !drain_q))
    else $error("ifu_fetch: response outside WAIT with no drain pending");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a bus/core model drives each step and a
// scoreboard queue holds the word and fault expected for every issued PC.
module tb_ifu_fetch;

  localparam int unsigned TB_TMO = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] inst;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  ifu_fetch #(
    .TIMEOUT  (TB_TMO),
    .NOP_INST (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .fault          (fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_resp_ready", 32'(mem_resp_ready), 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
  endtask

  // Leaves the bench at a negedge with rst low and the DUT about to sample pc_in.
  task automatic do_reset();
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    inst_ready     = 1'b0;
    step();
    step();
    chk_reset_outputs();
    sb.delete();
    exp_cnt = '0;
    rst     = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef);
    exp_t e;
    e.inst  = ei;
    e.fault = ef;
    pc_in   = pc;
    sb.push_back(e);
    step();
  endtask

  task automatic bus_req(input int n, input logic [31:0] addr);
    for (int i = 0; i < n; i++) begin
      chk("req_valid_hold", 32'(mem_req_valid), 32'h1);
      chk("req_addr_hold", mem_req_addr, addr);
      step();
    end
    chk("req_valid", 32'(mem_req_valid), 32'h1);
    chk("req_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_req_drop", 32'(mem_req_valid), 32'h0);
    chk("wait_resp_ready", 32'(mem_resp_ready), 32'h1);
  endtask

  task automatic bus_resp(input int n, input logic [31:0] data, input logic err);
    for (int i = 0; i < n; i++) begin
      chk("wait_no_inst", 32'(inst_valid), 32'h0);
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
  endtask

  // Core side: wait (bounded) for a word, compare with the scoreboard, stall n cycles, accept.
  task automatic core_take(input int n);
    exp_t e;
    for (int i = 0; i < 32 && inst_valid !== 1'b1; i++) step();
    chk("inst_valid", 32'(inst_valid), 32'h1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=empty expected=entry");
      e.inst  = 32'hBAD0_BAD0;
      e.fault = 2'b00;
    end
    chk("inst", inst, e.inst);
    chk("fault", 32'(fault), 32'(e.fault));
    for (int i = 0; i < n; i++) begin
      step();
      chk("inst_hold", inst, e.inst);
      chk("inst_valid_hold", 32'(inst_valid), 32'h1);
      chk("cnt_hold", fetch_cnt, exp_cnt);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    chk("inst_valid_drop", 32'(inst_valid), 32'h0);
    chk("cnt_after", fetch_cnt, exp_cnt);
  endtask

  initial begin
    rst   = 1'b1;
    pc_in = '0;
    do_reset();

    // Basic fetch, zero-wait bus: word valid on the third cycle after pc_in is sampled.
    issue(32'h8000_0000, 32'h0010_0093, 2'b00);
    bus_req(0, 32'h8000_0000);
    bus_resp(0, 32'h0010_0093, 1'b0);
    chk("lat3_valid", 32'(inst_valid), 32'h1);
    core_take(0);
    chk("cnt_one", fetch_cnt, 32'd1);

    // Request backpressure for 5 cycles, then the core stalls for 3 cycles.
    issue(32'h8000_0004, 32'h0020_0113, 2'b00);
    bus_req(5, 32'h8000_0004);
    bus_resp(0, 32'h0020_0113, 1'b0);
    core_take(3);

    // Misaligned PC: NOP with fault 10 after one cycle and no bus request.
    issue(32'h8000_0002, NOP, 2'b10);
    chk("mis_no_req", 32'(mem_req_valid), 32'h0);
    chk("mis_valid", 32'(inst_valid), 32'h1);
    core_take(0);

    // Bus error: the returned data is replaced by NOP.
    issue(32'h8000_0008, NOP, 2'b01);
    bus_req(1, 32'h8000_0008);
    bus_resp(1, 32'hDEAD_BEEF, 1'b1);
    core_take(0);

    // Response on the cycle the counter reaches TIMEOUT is taken normally.
    issue(32'h8000_000C, 32'hCAFE_0093, 2'b00);
    bus_req(0, 32'h8000_000C);
    bus_resp(TB_TMO - 1, 32'hCAFE_0093, 1'b0);
    core_take(0);
    chk("edge_no_drain", 32'(mem_resp_ready), 32'h0);

    // Timeout: four WAIT cycles with no response, then NOP with fault 11.
    issue(32'h8000_0010, NOP, 2'b11);
    bus_req(0, 32'h8000_0010);
    for (int i = 0; i < int'(TB_TMO); i++) begin
      chk("tmo_wait", 32'(inst_valid), 32'h0);
      step();
    end
    chk("tmo_drain_ready", 32'(mem_resp_ready), 32'h1);
    core_take(0);

    // Next fetch is held off until the late response drains; its data is discarded.
    issue(32'h8000_0014, 32'h0000_0297, 2'b00);
    for (int i = 0; i < 3; i++) begin
      chk("drain_no_req", 32'(mem_req_valid), 32'h0);
      chk("drain_resp_ready", 32'(mem_resp_ready), 32'h1);
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk("drain_done_ready", 32'(mem_resp_ready), 32'h0);
    bus_req(0, 32'h8000_0014);
    bus_resp(1, 32'h0000_0297, 1'b0);
    core_take(0);

    // Reset while waiting for a response drops the transaction.
    issue(32'h8000_0018, 32'h0000_0001, 2'b00);
    bus_req(0, 32'h8000_0018);
    rst = 1'b1;
    step();
    chk_reset_outputs();
    sb.delete();
    exp_cnt = '0;
    rst     = 1'b0;

    // 200 back-to-back fetches.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] pc;
      logic [31:0] w;
      pc = 32'h8000_0000 + 32'(i * 4);
      w  = 32'h0000_0033 | (32'(i) << 7);
      issue(pc, w, 2'b00);
      bus_req(0, pc);
      bus_resp(0, w, 1'b0);
      core_take(0);
    end
    chk("cnt_200", fetch_cnt, 32'd200);

    // Counter wrap from all-ones.
    issue(32'h9000_0000, 32'h0000_0513, 2'b00);
    bus_req(0, 32'h9000_0000);
    bus_resp(0, 32'h0000_0513, 1'b0);
    dut.fetch_cnt_q = 32'hFFFF_FFFF;
    exp_cnt         = 32'hFFFF_FFFF;
    core_take(1);
    chk("cnt_wrap", fetch_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit sitting directly upstream of the single-cycle core.
- Takes the core's current PC.
- Issues a read on the instruction memory bus using a valid/ready handshake.
- Holds the returned word stable for the core until the core accepts it.
- Reports fetch faults: bus error, misaligned PC and response timeout. On any fault the core receives a NOP.

Parameters:
TIMEOUT, 255, max cycles in WAIT without mem_resp_valid before declaring a timeout fault (1..255)
NOP_INST, 32'h00000013, word delivered on any fault (addi x0,x0,0)

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
pc_in  in  32  core PC; sampled in IDLE only
inst  out  32  instruction to core; stable while inst_valid=1
inst_valid  out  1  inst/fault valid for core
inst_ready  in  1  core accepts inst this cycle (core PC updates at the same edge)
fault  out  2  00 none, 01 bus error, 10 misaligned, 11 timeout; valid with inst_valid
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  32  request address; stable while mem_req_valid=1 and not accepted
mem_resp_valid  in  1  response valid
mem_resp_ready  out  1  unit can take response
mem_resp_data  in  32  response word
mem_resp_err  in  1  bus error, qualified by mem_resp_valid
fetch_cnt  out  32  count of accepted instructions (inst_valid & inst_ready); wraps 0xFFFFFFFF->0

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; inst=0, inst_valid=0, fault=00.
  - mem_req_valid=0, mem_req_addr=0, mem_resp_ready=0.
  - fetch_cnt=0; timeout counter=0; drain=0.
  - Reset mid-transaction drops the outstanding request without waiting. The bus is reset by the same rst.
- FSM states: IDLE, REQ, WAIT, VALID. Registered outputs throughout; no combinational path from mem_* to inst*.
- IDLE:
  - Latch pc_q=pc_in.
  - If pc_in[1:0]!=0: go to VALID with inst=NOP_INST, fault=10, and no bus request.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1 and mem_req_addr=pc_q, unless drain=1, in which case mem_req_valid=0 and the unit stays in REQ.
  - On mem_req_valid & mem_req_ready: go to WAIT and clear the timeout counter.
  - Address and valid must not change until the handshake completes.
- WAIT:
  - mem_resp_ready=1; the timeout counter increments each cycle.
  - On mem_resp_valid: inst=mem_resp_data, fault=00. If mem_resp_err=1, inst=NOP_INST and fault=01. Go to VALID.
  - If the counter reaches TIMEOUT with no response: inst=NOP_INST, fault=11, drain=1, go to VALID.
  - A response in the same cycle the counter reaches TIMEOUT is accepted normally; the response wins.
- VALID:
  - inst_valid=1.
  - On inst_ready: inst_valid=0, fetch_cnt+=1, go to IDLE.
  - Because the core's PC updates at the accept edge, IDLE samples the new PC on the next cycle.
- Drain:
  - While drain=1, mem_resp_ready=1 in every state.
  - The first mem_resp_valid clears drain; its data and error are discarded and never affect inst.
- Latency: pc_in sampled to inst_valid takes at least 3 cycles (IDLE, REQ, WAIT), with zero-wait bus. A misaligned PC reaches VALID after 1 cycle.
- Steady-state throughput: 1 instruction per 4 cycles with zero-wait bus and an immediately ready core.
- mem_resp_valid outside WAIT with drain=0 is a bus protocol violation. It is ignored; an assertion flags it in simulation.

Test Plan:
- Reset then pc_in=0x80000000, mem_req_ready=1, response 0x00100093 one cycle later, inst_ready=1 → mem_req_addr=0x80000000 seen 1 cycle after IDLE; inst=0x00100093, fault=00; fetch_cnt=1.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid=1 and addr held constant all 5 cycles; inst_ready low for 3 cycles in VALID → inst stable and fetch_cnt unchanged until accept.
- pc_in=0x80000002 → no mem_req_valid; inst=0x00000013, fault=10 one cycle after IDLE.
- Response with mem_resp_err=1, data 0xDEADBEEF → inst=0x00000013, fault=01.
- TIMEOUT=4, no response → fault=11 after 4 WAIT cycles. Next fetch holds mem_req_valid=0 until a late response (0x12345678) arrives and is discarded. The next fetch then returns the correct word.
- Assert rst in WAIT → next cycle all outputs at reset values. 200 back-to-back fetches give fetch_cnt=200; forced preload 0xFFFFFFFF plus one accept gives 0.
